// File: rtl/tick_arbiter_timer_pkg.sv
// rtl/tick_arbiter_timer_pkg.sv - shared state encoding and defaults for the tick arbiter timer
package tick_arbiter_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/tick_arbiter_timer_if.sv
// rtl/tick_arbiter_timer_if.sv - tick/request/delay inputs and grant/done/status outputs
interface tick_arbiter_timer_if
  import tick_arbiter_timer_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = DEF_CNT_W
);

  logic                    iTick;
  logic [NREQ-1:0]         iReq;
  logic [NREQ*CNT_W-1:0]   iDelay;
  logic [NREQ-1:0]         oGrant;
  logic [NREQ-1:0]         oDone;
  logic                    oBusy;
  logic [CNT_W-1:0]        oRemaining;

  modport master (
    output iTick, iReq, iDelay,
    input  oGrant, oDone, oBusy, oRemaining
  );

  modport slave (
    input  iTick, iReq, iDelay,
    output oGrant, oDone, oBusy, oRemaining
  );

endinterface

// File: rtl/tick_arbiter_timer_rr_arbiter.sv
// rtl/tick_arbiter_timer_rr_arbiter.sv - combinational round-robin pick: first request at or after ptr
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int cand;

  // Scanning from the far end lets the nearest candidate overwrite later ones.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % NREQ;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/tick_arbiter_timer.sv
// rtl/tick_arbiter_timer.sv - one tick down-counter time-shared round-robin among NREQ requesters
module tick_arbiter_timer
  import tick_arbiter_timer_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               iclk,
  input  logic               irst_n,
  tick_arbiter_timer_if.slave bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] owner_inc;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [CNT_W-1:0] load_delay;
  logic [NREQ-1:0]  owner_oh;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req   (bus.iReq),
    .ptr   (ptr),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  assign load_delay = bus.iDelay[arb_idx*CNT_W +: CNT_W];
  assign owner_inc  = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign owner_oh   = NREQ'(1) << owner;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state     <= ST_IDLE;
      owner     <= '0;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    ptr_nxt       = ptr;
    remaining_nxt = remaining;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          owner_nxt     = arb_idx;
          remaining_nxt = load_delay;
          state_nxt     = (load_delay != '0) ? ST_COUNT : ST_DONE;
        end
      end
      ST_COUNT: begin
        // A withdrawn request outranks a tick arriving on the same edge.
        if (!bus.iReq[owner]) begin
          remaining_nxt = '0;
          ptr_nxt       = owner_inc;
          state_nxt     = ST_IDLE;
        end else if (bus.iTick) begin
          remaining_nxt = remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        ptr_nxt   = owner_inc;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt     = ST_IDLE;
        remaining_nxt = '0;
      end
    endcase
  end

  // Outputs decode registered state only, so inputs never reach them combinationally.
  assign bus.oGrant     = (state != ST_IDLE) ? owner_oh : '0;
  assign bus.oDone      = (state == ST_DONE) ? owner_oh : '0;
  assign bus.oBusy      = (state != ST_IDLE);
  assign bus.oRemaining = remaining;

endmodule
